wishbone_master: RTL
====================

Name: wishbone_master

Overview:
Command-driven Wishbone B4 classic-cycle master. It is the upstream stage that drives wishbone_slave-style targets from the test fabric and example top. It accepts single or incrementing-burst read/write commands on a valid/ready interface and streams write data in and read data out. It handles ACK/ERR/RTY termination and returns one status response per command.

Parameters:
WB_ADDR_W, 32, address width
WB_DATA_W, 32, data width (multiple of 8)
WB_TGD_W, 8, data tag width
WB_TGC_W, 4, cycle tag width
WB_TGA_W, 2, address tag width
MAX_RETRY, 3, RTY_I re-issues allowed per beat before abort
TIMEOUT_CYC, 256, watchdog limit in cycles (used only with the optional feature)

Ports:
CLK_I  in  1  clock
RST_I  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  high only in IDLE
cmd_we  in  1  1=write, 0=read
cmd_adr  in  WB_ADDR_W  start byte address
cmd_sel  in  WB_DATA_W/8  byte select, same for all beats
cmd_len  in  4  beats minus 1 (1..16 beats)
cmd_lock  in  1  drive LOCK_O for the whole cycle
cmd_tgc  in  WB_TGC_W  cycle tag
wdat  in  WB_DATA_W  write beat data
wdat_tgd  in  WB_TGD_W  write beat tag
wdat_valid  in  1  write data valid
wdat_ready  out  1  write data accept (WDAT state)
rdat  out  WB_DATA_W  read data, captured from DAT_I on ACK
rdat_valid  out  1  one-cycle pulse per acked read beat
rsp_valid  out  1  one-cycle pulse at command end
rsp_status  out  2  0=OK, 1=ERR, 2=retry exhausted, 3=timeout
rsp_beats  out  5  beats completed with ACK
ADR_O  out  WB_ADDR_W  address
DAT_O  out  WB_DATA_W  write data
DAT_I  in  WB_DATA_W  read data
SEL_O  out  WB_DATA_W/8  byte select
WE_O  out  1  write enable
STB_O  out  1  strobe
CYC_O  out  1  cycle
LOCK_O  out  1  lock
ACK_I  in  1  acknowledge
ERR_I  in  1  error
RTY_I  in  1  retry
TGD_O  out  WB_TGD_W  data tag
TGA_O  out  WB_TGA_W  address tag = beat index[WB_TGA_W-1:0]
TGC_O  out  WB_TGC_W  cycle tag, latched at command accept

Behaviour:
- Reset (RST_I low, asynchronous): all outputs 0, FSM to IDLE, counters cleared. This applies mid-burst: CYC_O and STB_O fall immediately, and no rsp is issued for the aborted command.
- States: IDLE, WDAT, REQ, GAP, RSP.
- IDLE: cmd_ready=1. Handshake latches the command.
  - Write command: go to WDAT.
  - Read command: go to REQ.
  - In both cases CYC_O rises with the transition and stays high until RSP.
- WDAT: wdat_ready=1. On wdat_valid, latch DAT_O/TGD_O and go to REQ. CYC_O stays high while waiting; STB_O stays 0.
- REQ: STB_O=1, ADR_O/SEL_O/WE_O stable. Terminations are sampled only while STB_O=1, with priority ERR_I > RTY_I > ACK_I.
  - ACK_I: beats+1. For a read, rdat<=DAT_I and rdat_valid pulses the next cycle. If this was the last beat, go to RSP with status 0; otherwise go to GAP.
  - ERR_I: go to RSP with status 1.
  - RTY_I: if the beat's retry count is below MAX_RETRY, increment it and go to GAP to re-issue the same beat. Otherwise go to RSP with status 2.
- GAP: exactly one cycle with STB_O=0 and CYC_O=1.
  - After an ACK: ADR_O += WB_DATA_W/8 (wraps modulo 2^WB_ADDR_W) and the retry count clears. Then go to WDAT (write) or REQ (read).
  - After an RTY: the address is unchanged. A write goes back to REQ with the same data, without a new wdat handshake.
- RSP: CYC_O=0, STB_O=0, LOCK_O=0. rsp_valid=1 for one cycle, then go to IDLE.
- Minimum single-beat latency: accept at cycle 0 → STB_O at cycle 1 (read) → ACK at cycle k → rsp_valid at k+1.
- If ACK_I, ERR_I and RTY_I are asserted together, ERR_I wins.
- Terminations arriving while STB_O=0 are ignored.

Optional Feature:
WB_MASTER_TIMEOUT_EN:
- Defined: a watchdog counts cycles with STB_O=1 and no termination. It clears whenever STB_O falls. When it reaches TIMEOUT_CYC, the FSM goes to RSP with status 3 and CYC_O/STB_O drop.
- Undefined: no counter is built, the master waits indefinitely, and status 3 is never produced.

Test Plan:
- Single write adr 0x1000, wdat 0xDEADBEEF, sel 0xF, slave acks 1 cycle after STB → STB_O high 2 cycles, WE_O=1, DAT_O=0xDEADBEEF; rsp status 0, beats 1.
- Read burst, len=3, adr 0x100, slave returns 0xA0..0xA3 → ADR_O 0x100/0x104/0x108/0x10C, one GAP cycle between beats; 4 rdat_valid pulses with 0xA0..0xA3; rsp status 0, beats 4.
- RTY twice then ACK, MAX_RETRY=3 → same address re-issued 3 times; status 0. RTY 4 times → status 2, beats 0.
- ERR on beat 2 of a 4-beat write → rsp status 1, beats 1; CYC_O low the next cycle.
- RST_I low during beat 3 of a burst → CYC_O/STB_O 0 immediately, no rsp_valid; a new command after reset completes normally.
- Timeout (with WB_MASTER_TIMEOUT_EN), TIMEOUT_CYC=8, slave silent → status 3 after 8 STB cycles. Without the macro, STB_O is still high after 1000 cycles.

Source files
------------

// File: rtl/wishbone_master.sv
// ---------------------------------------------------------------------------
// wishbone_master
//
// Purpose:
//   Command-driven Wishbone B4 classic-cycle master. Accepts single or
//   incrementing-burst read/write commands on a valid/ready interface. Write
//   beat data streams in and read beat data streams out. The master handles
//   ACK/ERR/RTY terminations and returns one status response per command.
//
// Optional feature (compile-time macro WB_MASTER_TIMEOUT_EN):
//   When defined, a watchdog aborts a strobe that has seen no termination
//   for TIMEOUT_CYC cycles and responds with status 3. When undefined, no
//   counter exists and the master waits indefinitely.
//
// Ports:
//   CLK_I, RST_I              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only while idle)
//   cmd_we, cmd_adr, cmd_sel  direction, start byte address, byte select
//   cmd_len                   beats minus one (1..16 beats)
//   cmd_lock, cmd_tgc         bus lock request, cycle tag
//   wdat, wdat_tgd            write beat data and data tag
//   wdat_valid/wdat_ready     write beat handshake
//   rdat, rdat_valid          read beat data, one-cycle pulse per acked beat
//   rsp_valid                 one-cycle pulse at command end
//   rsp_status                0=OK 1=ERR 2=retry exhausted 3=timeout
//   rsp_beats                 beats completed with ACK
//   ADR_O, DAT_O, DAT_I, SEL_O, WE_O, STB_O, CYC_O, LOCK_O,
//   ACK_I, ERR_I, RTY_I, TGD_O, TGA_O, TGC_O   Wishbone B4 master side
// ---------------------------------------------------------------------------
module wishbone_master #(
    parameter int WB_ADDR_W   = 32,
    parameter int WB_DATA_W   = 32,
    parameter int WB_TGD_W    = 8,
    parameter int WB_TGC_W    = 4,
    parameter int WB_TGA_W    = 2,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_we,
    input  logic [WB_ADDR_W-1:0]   cmd_adr,
    input  logic [WB_DATA_W/8-1:0] cmd_sel,
    input  logic [3:0]             cmd_len,
    input  logic                   cmd_lock,
    input  logic [WB_TGC_W-1:0]    cmd_tgc,
    input  logic [WB_DATA_W-1:0]   wdat,
    input  logic [WB_TGD_W-1:0]    wdat_tgd,
    input  logic                   wdat_valid,
    output logic                   wdat_ready,
    output logic [WB_DATA_W-1:0]   rdat,
    output logic                   rdat_valid,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_status,
    output logic [4:0]             rsp_beats,
    output logic [WB_ADDR_W-1:0]   ADR_O,
    output logic [WB_DATA_W-1:0]   DAT_O,
    input  logic [WB_DATA_W-1:0]   DAT_I,
    output logic [WB_DATA_W/8-1:0] SEL_O,
    output logic                   WE_O,
    output logic                   STB_O,
    output logic                   CYC_O,
    output logic                   LOCK_O,
    input  logic                   ACK_I,
    input  logic                   ERR_I,
    input  logic                   RTY_I,
    output logic [WB_TGD_W-1:0]    TGD_O,
    output logic [WB_TGA_W-1:0]    TGA_O,
    output logic [WB_TGC_W-1:0]    TGC_O
);

    localparam int SEL_W   = WB_DATA_W / 8;
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0]   RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [WB_ADDR_W-1:0] ADR_STEP    = WB_ADDR_W'(SEL_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDAT,
        S_REQ,
        S_GAP,
        S_RSP
    } state_t;

    state_t                 state_q, state_d;
    logic [WB_ADDR_W-1:0]   adr_q, adr_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   we_q, we_d;
    logic                   lock_q, lock_d;
    logic [WB_TGC_W-1:0]    tgc_q, tgc_d;
    logic [3:0]             len_q, len_d;
    logic [4:0]             beats_q, beats_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [WB_DATA_W-1:0]   dat_q, dat_d;
    logic [WB_TGD_W-1:0]    tgd_q, tgd_d;
    logic [WB_DATA_W-1:0]   rdat_q, rdat_d;
    logic                   rdat_valid_q, rdat_valid_d;
    logic [1:0]             status_q, status_d;
    logic                   gap_to_wdat_q, gap_to_wdat_d;
    logic                   timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    logic [WDOG_W-1:0] wdog_q;

    // Counts strobe cycles without a termination; any other state clears it,
    // so each re-issued beat starts a fresh timeout window.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            wdog_q <= '0;
        end else if (state_q == S_REQ && !(ACK_I || ERR_I || RTY_I)) begin
            wdog_q <= wdog_q + 1'b1;
        end else begin
            wdog_q <= '0;
        end
    end

    // Fires on the TIMEOUT_CYC-th silent strobe cycle so STB_O is high for
    // exactly TIMEOUT_CYC cycles before the abort.
    assign timeout_hit = (state_q == S_REQ) && !(ACK_I || ERR_I || RTY_I)
                         && (wdog_q == WDOG_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers; reset clears every registered output so
    // the bus is released immediately, even mid-burst.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q       <= S_IDLE;
            adr_q         <= '0;
            sel_q         <= '0;
            we_q          <= 1'b0;
            lock_q        <= 1'b0;
            tgc_q         <= '0;
            len_q         <= '0;
            beats_q       <= '0;
            retry_q       <= '0;
            dat_q         <= '0;
            tgd_q         <= '0;
            rdat_q        <= '0;
            rdat_valid_q  <= 1'b0;
            status_q      <= '0;
            gap_to_wdat_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            adr_q         <= adr_d;
            sel_q         <= sel_d;
            we_q          <= we_d;
            lock_q        <= lock_d;
            tgc_q         <= tgc_d;
            len_q         <= len_d;
            beats_q       <= beats_d;
            retry_q       <= retry_d;
            dat_q         <= dat_d;
            tgd_q         <= tgd_d;
            rdat_q        <= rdat_d;
            rdat_valid_q  <= rdat_valid_d;
            status_q      <= status_d;
            gap_to_wdat_q <= gap_to_wdat_d;
        end
    end

    // Next-state logic. Terminations are only looked at in S_REQ (STB_O=1),
    // with ERR over RTY over ACK.
    always_comb begin
        state_d       = state_q;
        adr_d         = adr_q;
        sel_d         = sel_q;
        we_d          = we_q;
        lock_d        = lock_q;
        tgc_d         = tgc_q;
        len_d         = len_q;
        beats_d       = beats_q;
        retry_d       = retry_q;
        dat_d         = dat_q;
        tgd_d         = tgd_q;
        rdat_d        = rdat_q;
        rdat_valid_d  = 1'b0;
        status_d      = status_q;
        gap_to_wdat_d = gap_to_wdat_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    adr_d    = cmd_adr;
                    sel_d    = cmd_sel;
                    we_d     = cmd_we;
                    lock_d   = cmd_lock;
                    tgc_d    = cmd_tgc;
                    len_d    = cmd_len;
                    beats_d  = '0;
                    retry_d  = '0;
                    status_d = 2'd0;
                    state_d  = cmd_we ? S_WDAT : S_REQ;
                end
            end
            S_WDAT: begin
                if (wdat_valid) begin
                    dat_d   = wdat;
                    tgd_d   = wdat_tgd;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ERR_I) begin
                    status_d = 2'd1;
                    state_d  = S_RSP;
                end else if (RTY_I) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d       = retry_q + 1'b1;
                        gap_to_wdat_d = 1'b0;
                        state_d       = S_GAP;
                    end else begin
                        status_d = 2'd2;
                        state_d  = S_RSP;
                    end
                end else if (ACK_I) begin
                    beats_d = beats_q + 1'b1;
                    if (!we_q) begin
                        rdat_d       = DAT_I;
                        rdat_valid_d = 1'b1;
                    end
                    if (beats_q == {1'b0, len_q}) begin
                        status_d = 2'd0;
                        state_d  = S_RSP;
                    end else begin
                        // Advance now so the next beat's address is ready
                        // when STB_O rises again after the gap.
                        adr_d         = adr_q + ADR_STEP;
                        retry_d       = '0;
                        gap_to_wdat_d = we_q;
                        state_d       = S_GAP;
                    end
                end else if (timeout_hit) begin
                    status_d = 2'd3;
                    state_d  = S_RSP;
                end
            end
            S_GAP: begin
                state_d = gap_to_wdat_q ? S_WDAT : S_REQ;
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign wdat_ready = (state_q == S_WDAT);
    assign CYC_O      = (state_q == S_WDAT) || (state_q == S_REQ) || (state_q == S_GAP);
    assign STB_O      = (state_q == S_REQ);
    assign LOCK_O     = lock_q && CYC_O;
    assign ADR_O      = adr_q;
    assign DAT_O      = dat_q;
    assign SEL_O      = sel_q;
    assign WE_O       = we_q;
    assign TGD_O      = tgd_q;
    assign TGC_O      = tgc_q;
    // The acked-beat count doubles as the index of the beat in flight.
    assign TGA_O      = WB_TGA_W'(beats_q);
    assign rdat       = rdat_q;
    assign rdat_valid = rdat_valid_q;
    assign rsp_valid  = (state_q == S_RSP);
    assign rsp_status = status_q;
    assign rsp_beats  = beats_q;

endmodule
